// File: rtl/bch_stream_encoder_pkg.sv
// Shared types and helpers for the streaming BCH encoder.
// Default code geometry, beat counts, state enum and a clog2 helper.
package bch_stream_encoder_pkg;

    localparam int DEF_M         = 4;
    localparam int DEF_T         = 2;
    localparam int DEF_DATA_BITS = 7;
    localparam int DEF_ECC_BITS  = 8;
    localparam int DEF_BITS      = 1;

    localparam int DATA_BEATS = DEF_DATA_BITS / DEF_BITS;
    localparam int ECC_BEATS  = DEF_ECC_BITS / DEF_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ECC  = 2'd2
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/bch_stream_encoder_lfsr.sv
// One BITS-wide step of Galois division of the parity register by GEN.
// Ports: lfsr_in/lfsr_out parity state, din message beat (MSB earliest),
// zero_fb forces feedback off so the step becomes a plain left shift.
module bch_lfsr_step #(
    parameter int                ECC_BITS = 8,
    parameter int                BITS     = 1,
    parameter logic [ECC_BITS:0] GEN      = 9'h1D1
) (
    input  logic [ECC_BITS-1:0] lfsr_in,
    input  logic [BITS-1:0]     din,
    input  logic                zero_fb,
    output logic [ECC_BITS-1:0] lfsr_out
);

    logic [ECC_BITS-1:0] acc;
    logic                fb;

    always_comb begin
        acc = lfsr_in;
        fb  = 1'b0;
        for (int j = BITS - 1; j >= 0; j--) begin
            fb  = ~zero_fb & (din[j] ^ acc[ECC_BITS-1]);
            acc = (acc << 1) ^ (fb ? GEN[ECC_BITS-1:0] : '0);
        end
        lfsr_out = acc;
    end

endmodule

// File: rtl/bch_stream_encoder.sv
// Systematic streaming BCH encoder: forwards the message, then its parity.
// Ports: clk, reset (async active-low), start/ready accept handshake, ce
// clock enable, data_in beat; registered data_out with data_bits/ecc_bits
// beat-type flags and first/last codeword framing.
module bch_stream_encoder
    import bch_stream_encoder_pkg::*;
#(
    parameter int                M         = DEF_M,
    parameter int                T         = DEF_T,
    parameter int                DATA_BITS = DEF_DATA_BITS,
    parameter int                ECC_BITS  = DEF_ECC_BITS,
    parameter logic [ECC_BITS:0] GEN       = 9'h1D1,
    parameter int                BITS      = DEF_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            ready,
    input  logic            ce,
    input  logic [BITS-1:0] data_in,
    output logic [BITS-1:0] data_out,
    output logic            data_bits,
    output logic            ecc_bits,
    output logic            first,
    output logic            last
);

    localparam int N_DATA = DATA_BITS / BITS;
    localparam int N_ECC  = ECC_BITS / BITS;
    localparam int TOTAL  = N_DATA + N_ECC;
    localparam int CW     = clog2(TOTAL);

    localparam logic [CW-1:0] DATA_LAST = CW'(N_DATA - 1);
    localparam logic [CW-1:0] TOT_LAST  = CW'(TOTAL - 1);

    if ((DATA_BITS % BITS) != 0) begin : g_bad_data
        $error("DATA_BITS must be a multiple of BITS");
    end
    if ((ECC_BITS % BITS) != 0) begin : g_bad_ecc
        $error("ECC_BITS must be a multiple of BITS");
    end
    if (ECC_BITS > M * T) begin : g_bad_mt
        $error("ECC_BITS exceeds M*T");
    end
    if (GEN[0] != 1'b1 || GEN[ECC_BITS] != 1'b1) begin : g_bad_gen
        $error("GEN must have MSB and LSB set");
    end

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ECC_BITS-1:0] lfsr_q, lfsr_d;
    logic [BITS-1:0]     dout_q, dout_d;
    logic                dbits_q, dbits_d;
    logic                ebits_q, ebits_d;
    logic                first_q, first_d;
    logic                last_q, last_d;

    logic                accept;
    logic [ECC_BITS-1:0] step_in;
    logic [ECC_BITS-1:0] step_out;
    logic                step_shift;

    // The final parity beat is registered on the way into IDLE, so ready
    // is high while it is on data_out and a new word can follow directly.
    assign ready  = (state_q == IDLE);
    assign accept = start & ready & ce;

    // A new word starts from a clear remainder; in ECC the step only shifts.
    assign step_in    = (state_q == IDLE) ? '0 : lfsr_q;
    assign step_shift = (state_q == ECC);

    bch_lfsr_step #(
        .ECC_BITS (ECC_BITS),
        .BITS     (BITS),
        .GEN      (GEN)
    ) u_step (
        .lfsr_in  (step_in),
        .din      (data_in),
        .zero_fb  (step_shift),
        .lfsr_out (step_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        dout_d  = dout_q;
        dbits_d = dbits_q;
        ebits_d = ebits_q;
        first_d = first_q;
        last_d  = last_q;
        if (ce) begin
            unique case (state_q)
                IDLE: begin
                    dout_d  = '0;
                    dbits_d = 1'b0;
                    ebits_d = 1'b0;
                    first_d = 1'b0;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                    if (accept) begin
                        state_d = (N_DATA == 1) ? ECC : DATA;
                        cnt_d   = CW'(1);
                        lfsr_d  = step_out;
                        dout_d  = data_in;
                        dbits_d = 1'b1;
                        first_d = 1'b1;
                    end
                end
                DATA: begin
                    cnt_d   = cnt_q + CW'(1);
                    lfsr_d  = step_out;
                    dout_d  = data_in;
                    dbits_d = 1'b1;
                    ebits_d = 1'b0;
                    first_d = 1'b0;
                    last_d  = 1'b0;
                    if (cnt_q == DATA_LAST) begin
                        state_d = ECC;
                    end
                end
                ECC: begin
                    dout_d  = lfsr_q[ECC_BITS-1 -: BITS];
                    lfsr_d  = step_out;
                    dbits_d = 1'b0;
                    ebits_d = 1'b1;
                    first_d = 1'b0;
                    if (cnt_q == TOT_LAST) begin
                        last_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        last_d = 1'b0;
                        cnt_d  = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lfsr_q  <= '0;
            dout_q  <= '0;
            dbits_q <= 1'b0;
            ebits_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            dout_q  <= dout_d;
            dbits_q <= dbits_d;
            ebits_q <= ebits_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign data_out  = dout_q;
    assign data_bits = dbits_q;
    assign ecc_bits  = ebits_q;
    assign first     = first_q;
    assign last      = last_q;

endmodule

// File: tb/tb_bch_stream_encoder.sv
// Directed bench for bch_stream_encoder: BCH(15,7) bit-serial instance
// plus an 8+8 bit, 4-bit-beat instance.
module tb_bch_stream_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start0, ce0, rdy0, db0, eb0, f0, l0;
    logic [0:0] din0, dout0;
    logic       start1, ce1, rdy1, db1, eb1, f1, l1;
    logic [3:0] din1, dout1;

    int nchk = 0;
    int nerr = 0;

    bch_stream_encoder u0 (
        .clk       (clk),
        .reset     (reset),
        .start     (start0),
        .ready     (rdy0),
        .ce        (ce0),
        .data_in   (din0),
        .data_out  (dout0),
        .data_bits (db0),
        .ecc_bits  (eb0),
        .first     (f0),
        .last      (l0)
    );

    bch_stream_encoder #(
        .M         (5),
        .T         (2),
        .DATA_BITS (8),
        .ECC_BITS  (8),
        .GEN       (9'h1D1),
        .BITS      (4)
    ) u1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start1),
        .ready     (rdy1),
        .ce        (ce1),
        .data_in   (din1),
        .data_out  (dout1),
        .data_bits (db1),
        .ecc_bits  (eb1),
        .first     (f1),
        .last      (l1)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] v0(input logic d, input logic db,
        input logic eb, input logic f, input logic l, input logic r);
        return {10'b0, d, db, eb, f, l, r};
    endfunction

    function automatic logic [15:0] v1(input logic [3:0] d, input logic db,
        input logic eb, input logic f, input logic l, input logic r);
        return {7'b0, d, db, eb, f, l, r};
    endfunction

    function automatic logic [15:0] obs0();
        return {10'b0, dout0, db0, eb0, f0, l0, rdy0};
    endfunction

    function automatic logic [15:0] obs1();
        return {7'b0, dout1, db1, eb1, f1, l1, rdy1};
    endfunction

    task automatic word0(input logic [6:0] msg, input logic [7:0] par,
                         input bit stall, input int abort_at);
        logic [15:0] e;
        start0 = 1'b1;
        ce0    = 1'b1;
        din0   = msg[6];
        for (int i = 0; i < 15; i++) begin
            cyc();
            start0 = 1'b0;
            din0   = (i < 6) ? msg[5-i] : 1'b0;
            if (i < 7) e = v0(msg[6-i], 1'b1, 1'b0, i == 0, 1'b0, 1'b0);
            else       e = v0(par[14-i], 1'b0, 1'b1, 1'b0, i == 14, i == 14);
            chk($sformatf("w0 msg=%h beat%0d", msg, i), obs0(), e);
            if (i == abort_at) begin
                reset = 1'b0;
                #2;
                chk("w0 async reset", obs0(), v0(0, 0, 0, 0, 0, 1));
                reset = 1'b1;
                return;
            end
            if (stall && (i == 2 || i == 9)) begin
                ce0 = 1'b0;
                repeat (2) begin
                    cyc();
                    chk($sformatf("w0 hold beat%0d", i), obs0(), e);
                end
                ce0 = 1'b1;
            end
        end
    endtask

    task automatic word1(input logic [7:0] msg, input logic [7:0] par,
                         input int abort_at);
        logic [15:0] e;
        start1 = 1'b1;
        ce1    = 1'b1;
        din1   = msg[7:4];
        for (int i = 0; i < 4; i++) begin
            cyc();
            start1 = 1'b0;
            din1   = (i == 0) ? msg[3:0] : 4'h0;
            if (i == 0)      e = v1(msg[7:4], 1, 0, 1, 0, 0);
            else if (i == 1) e = v1(msg[3:0], 1, 0, 0, 0, 0);
            else if (i == 2) e = v1(par[7:4], 0, 1, 0, 0, 0);
            else             e = v1(par[3:0], 0, 1, 0, 1, 1);
            chk($sformatf("w1 msg=%h beat%0d", msg, i), obs1(), e);
            if (i == abort_at) begin
                reset = 1'b0;
                #2;
                chk("w1 async reset", obs1(), v1(0, 0, 0, 0, 0, 1));
                reset = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        reset  = 1'b0;
        start0 = 1'b0;
        ce0    = 1'b0;
        din0   = '0;
        start1 = 1'b0;
        ce1    = 1'b0;
        din1   = '0;

        repeat (2) cyc();
        chk("u0 in reset", obs0(), v0(0, 0, 0, 0, 0, 1));
        chk("u1 in reset", obs1(), v1(0, 0, 0, 0, 0, 1));
        #2 reset = 1'b1;
        cyc();
        chk("u0 idle", obs0(), v0(0, 0, 0, 0, 0, 1));
        chk("u1 idle", obs1(), v1(0, 0, 0, 0, 0, 1));

        ce0    = 1'b0;
        start0 = 1'b1;
        din0   = 1'b1;
        cyc();
        chk("u0 ce gates start", obs0(), v0(0, 0, 0, 0, 0, 1));
        start0 = 1'b0;
        ce0    = 1'b1;

        word0(7'h00, 8'h00, 1'b0, -1);
        start0 = 1'b0;
        cyc();
        chk("u0 idle after zero word", obs0(), v0(0, 0, 0, 0, 0, 1));

        word0(7'h01, 8'hD1, 1'b0, -1);
        start0 = 1'b0;
        cyc();
        chk("u0 idle after x0 word", obs0(), v0(0, 0, 0, 0, 0, 1));

        word0(7'h40, 8'hE8, 1'b0, -1);
        word0(7'h65, 8'hAB, 1'b0, -1);
        start0 = 1'b0;
        cyc();
        chk("u0 idle after b2b", obs0(), v0(0, 0, 0, 0, 0, 1));

        word0(7'h65, 8'hAB, 1'b1, -1);
        start0 = 1'b0;
        cyc();
        chk("u0 idle after stall", obs0(), v0(0, 0, 0, 0, 0, 1));

        word0(7'h65, 8'hAB, 1'b0, 9);
        word0(7'h01, 8'hD1, 1'b0, -1);
        start0 = 1'b0;
        cyc();
        chk("u0 idle after abort", obs0(), v0(0, 0, 0, 0, 0, 1));

        word1(8'h81, 8'hD0, -1);
        word1(8'h01, 8'hD1, -1);
        start1 = 1'b0;
        cyc();
        chk("u1 idle after b2b", obs1(), v1(0, 0, 0, 0, 0, 1));

        word1(8'h81, 8'hD0, 2);
        word1(8'h81, 8'hD0, -1);
        start1 = 1'b0;
        cyc();
        chk("u1 idle after abort", obs1(), v1(0, 0, 0, 0, 0, 1));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/bch_stream_encoder.md
Name: bch_stream_encoder

Overview:
- Systematic binary BCH encoder with a streaming, BITS-wide datapath.
- Accepts DATA_BITS message bits over DATA_BITS/BITS beats and forwards them unchanged.
- Then emits ECC_BITS parity bits (remainder of x^ECC_BITS·m(x) mod g(x)) over ECC_BITS/BITS beats.
- Sits between the data source and the channel/syndrome stage; all downstream framing uses its first/last/data_bits/ecc_bits flags.

Parameters:
- M, 4: Galois field degree; code length N = 2^M-1.
- T, 2: correctable errors; informational only, used for the legality check.
- DATA_BITS, 7: message bits K per codeword.
- ECC_BITS, 8: parity bits; must not exceed M*T.
- GEN, 9'h1D1: generator polynomial, ECC_BITS+1 bits, bit i = coefficient of x^i, MSB and LSB must be 1. Default is BCH(15,7): x^8+x^7+x^6+x^4+1.
- BITS, 1: bits per beat. DATA_BITS%BITS==0 and ECC_BITS%BITS==0 are required; elaboration fails otherwise.

Ports:
- clk, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: request to begin a codeword; its first data beat is on data_in this cycle.
- ready, output, 1: encoder can accept start this cycle.
- ce, input, 1: clock enable; when 0 all state and outputs hold.
- data_in, input, BITS: message beat; bit BITS-1 is earliest in time, i.e. the highest polynomial coefficient.
- data_out, output, BITS: registered codeword beat, same bit ordering as data_in.
- data_bits, output, 1: data_out carries a message beat.
- ecc_bits, output, 1: data_out carries a parity beat.
- first, output, 1: first beat of a codeword on data_out.
- last, output, 1: final parity beat on data_out.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, LFSR=0, data_out=0, data_bits=ecc_bits=first=last=0, ready=1.
- Accept rule: a word is accepted when start && ready && ce. The first data beat is sampled in that same cycle.
- Input sampling: the remaining DATA_BITS/BITS-1 beats are sampled on subsequent ce=1 cycles, one per cycle. During these cycles ready=0 and start is ignored.
- Output latency: one cycle. A beat sampled at edge n appears on data_out after edge n, with data_bits=1; first=1 only with beat 0.
- LFSR (Galois division by GEN, ECC_BITS wide), per data beat, BITS iterations with j from BITS-1 down to 0:
  - fb = data_in[j] ^ lfsr[ECC_BITS-1];
  - lfsr = (lfsr<<1) ^ (fb ? GEN[ECC_BITS-1:0] : 0).
  - It is cleared (loaded with only the first beat's contribution) on accept.
- ECC phase: the cycle after the last data beat leaves the input side, state moves to ECC. Each ce cycle outputs lfsr[ECC_BITS-1 -: BITS] on data_out with ecc_bits=1 and shifts lfsr left by BITS (zero fill). There are ECC_BITS/BITS beats in total.
- last=1 on the final parity beat.
- ready timing: ready=1 in IDLE and during the cycle whose registered output is the final parity beat. This allows back-to-back words with no gap: the next word's beat 0 follows the last ECC beat directly, with first=1.
- After the last beat with no new start, flags drop to 0 and the state returns to IDLE.
- Flag exclusivity: data_bits and ecc_bits are never both 1. first implies data_bits; last implies ecc_bits. With BITS=DATA_BITS and BITS=ECC_BITS, first and last still fall on distinct beats.
- ce=0 at any point: freezes the counter, LFSR, outputs and ready. There is no timeout.
- ready is combinational from state only and does not depend on start or ce. This keeps the path free of combinational loops when upstream logic gates ce with first or ready.
- Reset mid-word: abandons the word immediately and all outputs go to their reset values.
- Counter: log2(DATA_BITS/BITS + ECC_BITS/BITS) bits; wraps to 0 on word end.

Decomposition:
- Shared package holds:
  - beat-count constants: DATA_BEATS = DATA_BITS/BITS, ECC_BEATS = ECC_BITS/BITS;
  - a clog2 function;
  - the state enum {IDLE, DATA, ECC}.
- One sub-module is natural: bch_lfsr_step, a purely combinational BITS-bit division step of the LFSR by GEN, reused for both data absorption and parity shift-out (fb forced to 0).

Test Plan:
- Reset and idle: hold reset=0, then release → ready=1, all flags 0, data_out=0.
- All-zero message: default params, BITS=1, 7 beats of 0 → 7 data beats of 0 then 8 parity beats of 0. first on cycle 1 after accept, last on cycle 15.
- Message "0000001" (only x^0 set), BITS=1 → parity 1,1,0,1,0,0,0,1 in time order (0xD1). last on the 8th parity beat; ready=1 in that same cycle.
- Back-to-back: start held high with two words → the second word's first=1 immediately follows the first word's last=1 with no idle cycle; both parities are correct.
- ce stalls: random ce=0 cycles inserted mid-data and mid-ECC → outputs hold during stalls; the final codeword is identical to the unstalled run.
- Reset mid-ECC: assert reset during the 3rd parity beat → flags clear asynchronously, ready=1, and the next word encodes correctly. Repeat with BITS=... only divisor-legal widths (e.g. DATA_BITS=8, ECC_BITS=8, BITS=4).
